// File: rtl/object_transfer_pkg.sv
// Shared types and constants for the object_transfer sprite-RAM copy engine.
//   - xfer_state_e : engine FSM states
//   - obj_drive_t  : registered object-side bus drive (address, R/W, data enable)
//   - obj_addr()   : 13-bit modulo base+index address helper
package obj_xfer_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 12;

    localparam logic [ADDR_W-1:0] SRC_BASE_DEF = 13'h1800;
    localparam logic [ADDR_W-1:0] DST_BASE_DEF = 13'h1000;
    localparam int unsigned       LEN_DEF      = 2048;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RD,
        ST_READ,
        ST_WAIT_WR,
        ST_WRITE
    } xfer_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] oa;
        logic              rnw;
        logic              doe;
    } obj_drive_t;

    // Bus values whenever the engine is not in a read or write slot.
    localparam obj_drive_t IDLE_DRIVE = '{oa: '0, rnw: 1'b1, doe: 1'b0};

    // Base plus index, wrapping at the top of the 13-bit address space.
    function automatic logic [ADDR_W-1:0] obj_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        return ADDR_W'(base + ADDR_W'(idx));
    endfunction

endpackage

// File: rtl/object_transfer_if.sv
// Object-side bus bundle between the copy engine and the bus multiplexer.
//   CLK_1H, VBLANK, DI : into the engine (1H slot phase, vertical blank, read data)
//   OA, ORnW, DO, DOE  : engine bus drive (address, 1=read/0=write, write data, data enable)
//   BUSY               : transfer in progress
// master = engine side, slave = multiplexer / bench side.
interface object_transfer_if;
    import obj_xfer_pkg::*;

    logic              CLK_1H;
    logic              VBLANK;
    logic [DATA_W-1:0] DI;
    logic [ADDR_W-1:0] OA;
    logic              ORnW;
    logic [DATA_W-1:0] DO;
    logic              DOE;
    logic              BUSY;

    modport master (
        input  CLK_1H, VBLANK, DI,
        output OA, ORnW, DO, DOE, BUSY
    );

    modport slave (
        output CLK_1H, VBLANK, DI,
        input  OA, ORnW, DO, DOE, BUSY
    );

endinterface

// File: rtl/object_transfer_phase_edge.sv
// phase_edge: registered level sampler producing one-cycle rise/fall pulses.
//   clk_i   : sampling clock
//   rst_i   : synchronous active-high reset (sample and pulses cleared)
//   level_i : level to watch, synchronous to clk_i
//   rise_o  : registered pulse, level went 0->1
//   fall_o  : registered pulse, level went 1->0
module phase_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;
    logic rise_q;
    logic fall_q;

    // Pulses compare the incoming level against the previous sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_i;
            rise_q  <= level_i & ~level_q;
            fall_q  <= ~level_i & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/object_transfer.sv
// object_transfer: on each VBLANK rise, copy LEN bytes from work RAM at SRC_BASE
// to sprite RAM at DST_BASE, one read slot then one write slot per byte, using
// only the high phases of CLK_1H (object slots granted by the bus multiplexer).
//   CLK_6M : system clock (rising edge)
//   rst    : synchronous active-high reset, aborts any transfer
//   bus    : object_transfer_if.master (CLK_1H, VBLANK, DI in; OA, ORnW, DO, DOE, BUSY out)
// Build option OBJ_XFER_RESTART_EN: when defined, a VBLANK rise during a
// transfer restarts it from index 0; otherwise it is ignored.
module object_transfer
    import obj_xfer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SRC_BASE = SRC_BASE_DEF,
    parameter logic [ADDR_W-1:0] DST_BASE = DST_BASE_DEF,
    parameter int unsigned       LEN      = LEN_DEF
) (
    input logic               CLK_6M,
    input logic               rst,
    object_transfer_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    logic slot_rise;
    logic slot_fall;
    logic vb_rise;
    logic vb_fall_unused;

    xfer_state_e       state_q;
    logic [IDX_W-1:0]  idx_q;
    obj_drive_t        drive_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;

    phase_edge u_slot_edge (
        .clk_i   (CLK_6M),
        .rst_i   (rst),
        .level_i (bus.CLK_1H),
        .rise_o  (slot_rise),
        .fall_o  (slot_fall)
    );

    phase_edge u_vb_edge (
        .clk_i   (CLK_6M),
        .rst_i   (rst),
        .level_i (bus.VBLANK),
        .rise_o  (vb_rise),
        .fall_o  (vb_fall_unused)
    );

    // Copy FSM; bus drive is registered on the transition into each slot.
    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drive_q <= IDLE_DRIVE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vb_rise) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    // A slot already in progress at start is skipped: only a fresh rise counts.
                    if (slot_rise) begin
                        drive_q <= '{oa: obj_addr(SRC_BASE, idx_q), rnw: 1'b1, doe: 1'b0};
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (slot_fall) begin
                        data_q  <= bus.DI;
                        drive_q <= IDLE_DRIVE;
                        state_q <= ST_WAIT_WR;
                    end
                end
                ST_WAIT_WR: begin
                    if (slot_rise) begin
                        drive_q <= '{oa: obj_addr(DST_BASE, idx_q), rnw: 1'b0, doe: 1'b1};
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (slot_fall) begin
                        drive_q <= IDLE_DRIVE;
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_WAIT_RD;
                        end
                    end
                end
                default: begin
                    drive_q <= IDLE_DRIVE;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef OBJ_XFER_RESTART_EN
            // New frame mid-transfer: drop the current byte and start over.
            if (vb_rise && (state_q != ST_IDLE)) begin
                idx_q   <= '0;
                drive_q <= IDLE_DRIVE;
                state_q <= ST_WAIT_RD;
            end
`endif
        end
    end

    assign bus.OA   = drive_q.oa;
    assign bus.ORnW = drive_q.rnw;
    assign bus.DOE  = drive_q.doe;
    assign bus.DO   = data_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_object_transfer.sv
// Bench for object_transfer: two instances (LEN=4 from 1800, LEN=8 from 1FFE),
// expected slot contents queued when a transfer is triggered and compared at
// the middle of each CLK_1H high phase.
module tb_object_transfer;

    typedef struct packed {
        logic [12:0] oa;
        logic        rnw;
        logic        doe;
        logic [7:0]  dout;
        logic        chk;
    } slot_t;

    logic  clk;
    logic  clk_1h;
    logic  rst_a;
    logic  rst_b;
    int    n_checks;
    int    n_fail;
    slot_t exp_q[$];

    object_transfer_if ifa ();
    object_transfer_if ifb ();

    assign ifa.CLK_1H = clk_1h;
    assign ifb.CLK_1H = clk_1h;

    object_transfer #(.SRC_BASE(13'h1800), .DST_BASE(13'h1000), .LEN(4)) dut_a (
        .CLK_6M (clk),
        .rst    (rst_a),
        .bus    (ifa)
    );

    object_transfer #(.SRC_BASE(13'h1FFE), .DST_BASE(13'h1000), .LEN(8)) dut_b (
        .CLK_6M (clk),
        .rst    (rst_b),
        .bus    (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1H phase: 40 time units per level, edges well clear of CLK_6M rising edges.
    initial begin
        clk_1h = 1'b0;
        #12;
        forever #40 clk_1h = ~clk_1h;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic sample(input int sel, output logic [12:0] oa, output logic rnw,
                          output logic doe, output logic [7:0] dout, output logic busy);
        if (sel == 0) begin
            oa = ifa.OA; rnw = ifa.ORnW; doe = ifa.DOE; dout = ifa.DO; busy = ifa.BUSY;
        end else begin
            oa = ifb.OA; rnw = ifb.ORnW; doe = ifb.DOE; dout = ifb.DO; busy = ifb.BUSY;
        end
    endtask

    task automatic set_di(input int sel, input logic [7:0] v);
        if (sel == 0) ifa.DI = v;
        else          ifb.DI = v;
    endtask

    // Queue nbytes of read/write slots starting at byte index first.
    task automatic push_xfer(input logic [12:0] src, input logic [12:0] dst, input int first,
                             input int nbytes, input logic [7:0] di_base);
        slot_t e;
        for (int k = 0; k < nbytes; k++) begin
            e.oa = src + 13'(first + k); e.rnw = 1'b1; e.doe = 1'b0; e.dout = 8'h00; e.chk = 1'b0;
            exp_q.push_back(e);
            e.oa = dst + 13'(first + k); e.rnw = 1'b0; e.doe = 1'b1; e.dout = di_base + 8'(k); e.chk = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Walk n slots, driving DI at each read slot and checking each slot's bus drive.
    task automatic run_slots(input int sel, input int n, input logic [7:0] di_base, input string tag);
        slot_t       e;
        logic [12:0] oa;
        logic        rnw, doe, busy;
        logic [7:0]  dout;
        for (int s = 0; s < n; s++) begin
            @(posedge clk_1h);
            #1;
            if (s % 2 == 0) set_di(sel, di_base + 8'(s / 2));
            #17;
            sample(sel, oa, rnw, doe, dout, busy);
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL %s_queue slot %0d: observed empty expected entry", tag, s);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s_oa[%0d]", tag, s), 32'(oa), 32'(e.oa));
                check($sformatf("%s_rnw[%0d]", tag, s), 32'(rnw), 32'(e.rnw));
                check($sformatf("%s_doe[%0d]", tag, s), 32'(doe), 32'(e.doe));
                check($sformatf("%s_busy[%0d]", tag, s), 32'(busy), 32'd1);
                if (e.chk) check($sformatf("%s_do[%0d]", tag, s), 32'(dout), 32'(e.dout));
            end
        end
    endtask

    // One object slot with no bus activity and BUSY low.
    task automatic check_idle(input int sel, input string tag);
        logic [12:0] oa;
        logic        rnw, doe, busy;
        logic [7:0]  dout;
        @(posedge clk_1h);
        #18;
        sample(sel, oa, rnw, doe, dout, busy);
        check({tag, "_oa"}, 32'(oa), 32'd0);
        check({tag, "_rnw"}, 32'(rnw), 32'd1);
        check({tag, "_doe"}, 32'(doe), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [12:0] oa;
        logic        rnw, doe, busy;
        logic [7:0]  dout;
        n_checks = 0;
        n_fail   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.VBLANK = 1'b0; ifa.DI = 8'h00;
        ifb.VBLANK = 1'b0; ifb.DI = 8'h00;

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            sample(sel, oa, rnw, doe, dout, busy);
            check("rst_oa", 32'(oa), 32'd0);
            check("rst_rnw", 32'(rnw), 32'd1);
            check("rst_do", 32'(dout), 32'd0);
            check("rst_doe", 32'(doe), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Basic LEN=4 copy, VBLANK rising in a low 1H phase.
        @(negedge clk_1h);
        #20;
        ifa.VBLANK = 1'b1;
        push_xfer(13'h1800, 13'h1000, 0, 4, 8'hA0);
        #15;
        sample(0, oa, rnw, doe, dout, busy);
        check("start_busy", 32'(busy), 32'd1);
        check("start_oa", 32'(oa), 32'd0);
        run_slots(0, 8, 8'hA0, "basic");
        check_idle(0, "basic_done");

        // VBLANK kept high: no second transfer.
        for (int f = 0; f < 3; f++) check_idle(0, "vb_held");
        ifa.VBLANK = 1'b0;

        // VBLANK rising inside a high 1H phase: that partial slot is skipped.
        @(posedge clk_1h);
        #2;
        ifa.VBLANK = 1'b1;
        #16;
        sample(0, oa, rnw, doe, dout, busy);
        check("partial_busy", 32'(busy), 32'd1);
        check("partial_oa", 32'(oa), 32'd0);
        check("partial_rnw", 32'(rnw), 32'd1);
        check("partial_doe", 32'(doe), 32'd0);
        #20;
        sample(0, oa, rnw, doe, dout, busy);
        check("partial_oa_late", 32'(oa), 32'd0);
        push_xfer(13'h1800, 13'h1000, 0, 4, 8'hA0);
        run_slots(0, 8, 8'hA0, "aligned");
        check_idle(0, "aligned_done");
        ifa.VBLANK = 1'b0;

        // Reset asserted in the middle of a write slot.
        @(negedge clk_1h);
        #20;
        ifa.VBLANK = 1'b1;
        push_xfer(13'h1800, 13'h1000, 0, 1, 8'hA0);
        run_slots(0, 2, 8'hA0, "prerst");
        #1;
        rst_a = 1'b1;
        ifa.VBLANK = 1'b0;
        #9;
        sample(0, oa, rnw, doe, dout, busy);
        check("rstw_doe", 32'(doe), 32'd0);
        check("rstw_rnw", 32'(rnw), 32'd1);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_oa", 32'(oa), 32'd0);
        rst_a = 1'b0;
        for (int f = 0; f < 4; f++) check_idle(0, "after_rst");

        // Address wrap from 1FFE, then a VBLANK rise after four bytes.
        @(negedge clk_1h);
        #20;
        ifb.VBLANK = 1'b1;
        push_xfer(13'h1FFE, 13'h1000, 0, 4, 8'hA0);
        #15;
        sample(1, oa, rnw, doe, dout, busy);
        check("wrap_busy", 32'(busy), 32'd1);
        ifb.VBLANK = 1'b0;
        run_slots(1, 8, 8'hA0, "wrap");
        #40;
        ifb.VBLANK = 1'b1;
`ifdef OBJ_XFER_RESTART_EN
        push_xfer(13'h1FFE, 13'h1000, 0, 8, 8'hA0);
        run_slots(1, 16, 8'hA0, "restart");
`else
        push_xfer(13'h1FFE, 13'h1000, 4, 4, 8'hA4);
        run_slots(1, 8, 8'hA4, "norestart");
`endif
        check_idle(1, "late_done");
        check_idle(1, "late_quiet");
        ifb.VBLANK = 1'b0;

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL queue_drained: observed %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
